sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Parametrised N-sprite VGA compositor.
- Replaces the hand-wired per-image ROM address/colour paths in the board top with one reusable block.
- For each pixel from vga_controller it computes per-sprite ROM addresses and resolves sprite opacity by fixed priority into a 12-bit RGB pixel.
- Positions are double-buffered and latched at frame start; pixel-level sprite collisions are accumulated per frame.

Parameters:
- NUM_SPR, 4, number of sprites (1..8).
- SPR_W_LOG2, 7, log2 of sprite width in pixels (128).
- SPR_H_LOG2, 7, log2 of sprite height in pixels (128).
- COL_W, 10, column coordinate width.
- ROW_W, 9, row coordinate width.
- RGB_W, 12, pixel colour width (4:4:4).

Ports:
- vga_clk  in  1  pixel clock, 25 MHz.
- arst_n  in  1  reset, asynchronous, active-low.
- col  in  COL_W  current pixel column.
- row  in  ROW_W  current pixel row.
- disp_ena  in  1  active-video flag.
- frame_start  in  1  one-cycle pulse, issued only during vertical blanking.
- pos_wr_en  in  1  shadow position write strobe.
- pos_wr_idx  in  3  sprite index for the write.
- pos_wr_x  in  COL_W  new top-left column.
- pos_wr_y  in  ROW_W  new top-left row.
- spr_enable  in  NUM_SPR  per-sprite visibility.
- spr_color  in  NUM_SPR*RGB_W  per-sprite colour; sprite i occupies bits [i*RGB_W +: RGB_W].
- bg_color  in  RGB_W  background colour.
- rom_addr  out  NUM_SPR*(SPR_W_LOG2+SPR_H_LOG2)  per-sprite ROM read address.
- rom_opaque  in  NUM_SPR  per-sprite ROM bit (nonzero word = 1); sync ROM, 1-cycle latency.
- pix_rgb  out  RGB_W  composited pixel.
- pix_de  out  1  disp_ena delayed to align with pix_rgb.
- collision_mask  out  NUM_SPR  sprites involved in any collision in the previous frame.
- collision_valid  out  1  one-cycle pulse when collision_mask updates.

Behaviour:
- Reset values:
  - All outputs 0.
  - Shadow and active positions all (0,0).
  - Collision accumulator 0.
  - Pipeline valid/de bits 0.
- Pipeline (col/row presented in cycle t):
  - Edge t+1: register hit[i], rom_addr[i] and de1.
  - Edge t+2: ROM drives rom_opaque; hit and de are delayed to hit2 and de2.
  - Edge t+3: pix_rgb and pix_de are registered.
  - Fixed latency of 3 cycles; no stalls.
- Hit test, sprite i:
  - Condition: col >= x_i and col < x_i + 2^SPR_W_LOG2, and row >= y_i and row < y_i + 2^SPR_H_LOG2.
  - Sums are computed at COL_W+1 / ROW_W+1 bits, so sprites at the right/bottom edge clip and never wrap to column/row 0.
- Address:
  - rom_addr_i = {(row - y_i)[SPR_H_LOG2-1:0], (col - x_i)[SPR_W_LOG2-1:0]}, i.e. row*width + col.
  - Address is 0 when hit[i] = 0.
- Opacity: opaque[i] = hit2[i] & rom_opaque[i] & spr_enable[i]. spr_enable is sampled at t+2.
- Priority: the lowest-index opaque sprite wins.
  - pix_rgb = spr_color[winner]; bg_color if no sprite is opaque.
  - pix_rgb = 0 when de2 = 0.
- Positions:
  - pos_wr_en writes the shadow register [pos_wr_idx] at any time.
  - pos_wr_idx >= NUM_SPR is ignored.
  - On frame_start, all active registers load from shadow.
  - pos_wr_en in the same cycle as frame_start: the written value passes through to the active register (write-through).
  - Active positions never change mid-frame, so there is no tearing.
- Collision:
  - Event: de2 = 1 and popcount(opaque) >= 2.
  - On an event, accum |= opaque.
  - On frame_start: collision_mask <= accum, accum <= 0, collision_valid = 1 for that cycle.
  - An event in the frame_start cycle is ORed into the cleared (new) accumulator. This is unreachable in legal use because frame_start occurs in blanking.
- Reset asserted mid-frame: immediate clear of everything listed above. On release, outputs are valid from the 3rd cycle onward.

Decomposition:
- Package sprite_pkg:
  - SPR_ADDR_W = SPR_W_LOG2+SPR_H_LOG2.
  - RGB_W.
  - Typedef pos_t {x, y}.
  - Function onehot_first() for the priority pick.
- Sub-module sprite_hit_unit:
  - Per-sprite active-position register, hit test and address register.
  - Instantiated NUM_SPR times via generate.
  - Shadow/active load is controlled from the top.

Test Plan:
- Single sprite 0 at (256,176), ROM all-ones, colour 0x080, bg 0x000:
  - pixel (256,176) -> 0x080 three cycles later; (255,176) -> 0x000.
  - rom_addr at (300,200) = 24*128+44 = 3116.
- Overlap priority:
  - Sprite 0 at (100,100) colour 0xF00; sprite 2 at (150,150) colour 0x00F; both ROMs opaque.
  - (160,160) -> 0xF00; (240,240) -> 0x00F.
  - Next frame_start -> collision_valid = 1, collision_mask = 0b0101.
- Edge clipping:
  - Sprite at (600,400).
  - (639,479) is a hit with rom_addr = 79*128+39.
  - (0,0) is not a hit, confirming no wrap.
- Double buffering:
  - Write (10,10) mid-frame -> hits stay at the old position until frame_start, then move.
  - Write coinciding with frame_start -> new position is active immediately.
- Transparency/enable/blanking:
  - rom_opaque = 0 or spr_enable = 0 -> bg_color and no collision counted.
  - disp_ena = 0 -> pix_rgb = 0, pix_de = 0.
- Reset mid-frame:
  - Assert arst_n low during an overlap -> all outputs 0 next edge, collision_mask = 0, positions back to (0,0).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite compositor.
// Widths here are the defaults; the compositor parameters override them per instance.
package sprite_pkg;

   localparam int SPR_W_LOG2 = 7;
   localparam int SPR_H_LOG2 = 7;
   localparam int SPR_ADDR_W = SPR_W_LOG2 + SPR_H_LOG2;
   localparam int COL_W      = 10;
   localparam int ROW_W      = 9;
   localparam int RGB_W      = 12;
   localparam int MAX_SPR    = 8;

   typedef struct packed {
      logic [COL_W-1:0] x;
      logic [ROW_W-1:0] y;
   } pos_t;

   // Isolates the lowest set bit, which gives the lowest-index sprite the highest priority.
   function automatic logic [MAX_SPR-1:0] onehot_first(input logic [MAX_SPR-1:0] v);
      return v & (~v + MAX_SPR'(1));
   endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-timing, position-write and sprite-ROM signals between the board top and the compositor.
interface sprite_compositor_if #(
   parameter int NUM_SPR = 4,
   parameter int COL_W   = 10,
   parameter int ROW_W   = 9,
   parameter int ADDR_W  = 14
);

   logic [COL_W-1:0]          col;
   logic [ROW_W-1:0]          row;
   logic                      disp_ena;
   logic                      frame_start;
   logic                      pos_wr_en;
   logic [2:0]                pos_wr_idx;
   logic [COL_W-1:0]          pos_wr_x;
   logic [ROW_W-1:0]          pos_wr_y;
   logic [NUM_SPR*ADDR_W-1:0] rom_addr;
   logic [NUM_SPR-1:0]        rom_opaque;

   modport master (
      output col, row, disp_ena, frame_start,
      output pos_wr_en, pos_wr_idx, pos_wr_x, pos_wr_y,
      output rom_opaque,
      input  rom_addr
   );

   modport slave (
      input  col, row, disp_ena, frame_start,
      input  pos_wr_en, pos_wr_idx, pos_wr_x, pos_wr_y,
      input  rom_opaque,
      output rom_addr
   );

endinterface

// File: rtl/sprite_hit_unit.sv
// One sprite: active top-left position, bounding-box hit test and registered ROM address.
module sprite_hit_unit #(
   parameter int COL_W      = 10,
   parameter int ROW_W      = 9,
   parameter int SPR_W_LOG2 = 7,
   parameter int SPR_H_LOG2 = 7
) (
   input  logic                             vga_clk,
   input  logic                             arst_n,
   input  logic                             load,
   input  logic [COL_W-1:0]                 load_x,
   input  logic [ROW_W-1:0]                 load_y,
   input  logic [COL_W-1:0]                 col,
   input  logic [ROW_W-1:0]                 row,
   output logic                             hit,
   output logic [SPR_W_LOG2+SPR_H_LOG2-1:0] addr
);

   logic [COL_W-1:0] act_x;
   logic [ROW_W-1:0] act_y;
   logic [COL_W:0]   x_end;
   logic [ROW_W:0]   y_end;
   logic [COL_W-1:0] dcol;
   logic [ROW_W-1:0] drow;
   logic             hit_c;

   always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
         act_x <= '0;
         act_y <= '0;
      end else if (load) begin
         act_x <= load_x;
         act_y <= load_y;
      end
   end

   // The extra MSB on the far edges lets sprites near the right/bottom clip instead of wrapping.
   assign x_end = {1'b0, act_x} + ((COL_W+1)'(1) << SPR_W_LOG2);
   assign y_end = {1'b0, act_y} + ((ROW_W+1)'(1) << SPR_H_LOG2);
   assign dcol  = col - act_x;
   assign drow  = row - act_y;
   assign hit_c = (col >= act_x) && ({1'b0, col} < x_end) &&
                  (row >= act_y) && ({1'b0, row} < y_end);

   always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
         hit  <= 1'b0;
         addr <= '0;
      end else begin
         hit  <= hit_c;
         addr <= hit_c ? {drow[SPR_H_LOG2-1:0], dcol[SPR_W_LOG2-1:0]} : '0;
      end
   end

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite compositor: double-buffered positions, per-sprite ROM addressing, fixed-priority
// opacity resolve into one RGB pixel three clocks after col/row, plus per-frame collision mask.
module sprite_compositor #(
   parameter int NUM_SPR    = 4,
   parameter int SPR_W_LOG2 = sprite_pkg::SPR_W_LOG2,
   parameter int SPR_H_LOG2 = sprite_pkg::SPR_H_LOG2,
   parameter int COL_W      = sprite_pkg::COL_W,
   parameter int ROW_W      = sprite_pkg::ROW_W,
   parameter int RGB_W      = sprite_pkg::RGB_W
) (
   input  logic                     vga_clk,
   input  logic                     arst_n,
   sprite_compositor_if.slave       bus,
   input  logic [NUM_SPR-1:0]       spr_enable,
   input  logic [NUM_SPR*RGB_W-1:0] spr_color,
   input  logic [RGB_W-1:0]         bg_color,
   output logic [RGB_W-1:0]         pix_rgb,
   output logic                     pix_de,
   output logic [NUM_SPR-1:0]       collision_mask,
   output logic                     collision_valid
);

   import sprite_pkg::*;

   localparam int ADDR_W = SPR_W_LOG2 + SPR_H_LOG2;

   pos_t                      shadow_pos [NUM_SPR];
   pos_t                      load_pos   [NUM_SPR];
   logic                      wr_valid;
   logic [NUM_SPR-1:0]        hit1;
   logic [NUM_SPR-1:0]        hit2;
   logic                      de1;
   logic                      de2;
   logic [NUM_SPR*ADDR_W-1:0] addr_flat;
   logic [NUM_SPR-1:0]        opaque;
   logic [MAX_SPR-1:0]        winner;
   logic [RGB_W-1:0]          pix_next;
   logic                      coll_event;
   logic [NUM_SPR-1:0]        accum;

   assign wr_valid = bus.pos_wr_en && (int'(bus.pos_wr_idx) < NUM_SPR);

   always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < NUM_SPR; i++) shadow_pos[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SPR; i++)
            if (wr_valid && int'(bus.pos_wr_idx) == i)
               shadow_pos[i] <= '{x: bus.pos_wr_x, y: bus.pos_wr_y};
      end
   end

   // A write landing on the frame_start cycle bypasses the shadow so it takes effect this frame.
   always_comb begin
      for (int i = 0; i < NUM_SPR; i++) begin
         load_pos[i] = shadow_pos[i];
         if (bus.pos_wr_en && int'(bus.pos_wr_idx) == i)
            load_pos[i] = '{x: bus.pos_wr_x, y: bus.pos_wr_y};
      end
   end

   for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
      sprite_hit_unit #(
         .COL_W      (COL_W),
         .ROW_W      (ROW_W),
         .SPR_W_LOG2 (SPR_W_LOG2),
         .SPR_H_LOG2 (SPR_H_LOG2)
      ) u_hit (
         .vga_clk (vga_clk),
         .arst_n  (arst_n),
         .load    (bus.frame_start),
         .load_x  (load_pos[g].x),
         .load_y  (load_pos[g].y),
         .col     (bus.col),
         .row     (bus.row),
         .hit     (hit1[g]),
         .addr    (addr_flat[g*ADDR_W +: ADDR_W])
      );
   end

   assign bus.rom_addr = addr_flat;

   always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
         de1  <= 1'b0;
         de2  <= 1'b0;
         hit2 <= '0;
      end else begin
         de1  <= bus.disp_ena;
         de2  <= de1;
         hit2 <= hit1;
      end
   end

   assign opaque = hit2 & bus.rom_opaque & spr_enable;

   always_comb begin
      winner   = onehot_first(MAX_SPR'(opaque));
      pix_next = '0;
      if (de2) begin
         if (winner == '0) begin
            pix_next = bg_color;
         end else begin
            for (int i = 0; i < NUM_SPR; i++)
               if (winner[i]) pix_next = spr_color[i*RGB_W +: RGB_W];
         end
      end
   end

   always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
         pix_rgb <= '0;
         pix_de  <= 1'b0;
      end else begin
         pix_rgb <= pix_next;
         pix_de  <= de2;
      end
   end

   assign coll_event = de2 && ($countones(opaque) >= 2);

   // frame_start hands the finished frame's accumulator to the output and starts a fresh one.
   always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
         accum           <= '0;
         collision_mask  <= '0;
         collision_valid <= 1'b0;
      end else begin
         collision_valid <= bus.frame_start;
         if (bus.frame_start) begin
            collision_mask <= accum;
            accum          <= coll_event ? opaque : '0;
         end else if (coll_event) begin
            accum <= accum | opaque;
         end
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: stimulus pushes hand-computed pixels into a queue,
// a monitor pops and compares whenever pix_de is high.
module tb_sprite_compositor;

   localparam int NS = 4;
   localparam int AW = 14;

   logic             vga_clk = 1'b0;
   logic             arst_n  = 1'b0;
   logic [NS-1:0]    spr_enable;
   logic [NS*12-1:0] spr_color;
   logic [11:0]      bg_color;
   logic [11:0]      pix_rgb;
   logic             pix_de;
   logic [NS-1:0]    collision_mask;
   logic             collision_valid;
   logic [NS-1:0]    rom_on;

   int          total = 0;
   int          bad   = 0;
   logic [11:0] exp_q [$];

   sprite_compositor_if #(.NUM_SPR(NS), .COL_W(10), .ROW_W(9), .ADDR_W(AW)) bus ();

   sprite_compositor #(.NUM_SPR(NS)) dut (
      .vga_clk         (vga_clk),
      .arst_n          (arst_n),
      .bus             (bus),
      .spr_enable      (spr_enable),
      .spr_color       (spr_color),
      .bg_color        (bg_color),
      .pix_rgb         (pix_rgb),
      .pix_de          (pix_de),
      .collision_mask  (collision_mask),
      .collision_valid (collision_valid)
   );

   always #20 vga_clk = ~vga_clk;

   // Synchronous sprite ROM: each sprite's image is either fully opaque or fully transparent.
   always @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) bus.rom_opaque <= '0;
      else         bus.rom_opaque <= rom_on;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge vga_clk) begin
      if (arst_n && pix_de) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_pixel: got rgb %0h with no pixel expected", pix_rgb);
         end else begin
            checkOutput("pix_rgb", pix_rgb, exp_q.pop_front());
         end
      end
   end

   task automatic applyStimulus(input int c, input int r, input logic de, input logic [11:0] exp);
      @(posedge vga_clk); #1;
      bus.col      = 10'(c);
      bus.row      = 9'(r);
      bus.disp_ena = de;
      if (de) exp_q.push_back(exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge vga_clk); #1;
         bus.disp_ena = 1'b0;
      end
   endtask

   task automatic checkAddr(input string name, input int idx, input logic [AW-1:0] exp);
      checkOutput(name, 32'(bus.rom_addr[idx*AW +: AW]), 32'(exp));
   endtask

   task automatic writePos(input int idx, input int x, input int y);
      @(posedge vga_clk); #1;
      bus.pos_wr_en  = 1'b1;
      bus.pos_wr_idx = 3'(idx);
      bus.pos_wr_x   = 10'(x);
      bus.pos_wr_y   = 9'(y);
      @(posedge vga_clk); #1;
      bus.pos_wr_en  = 1'b0;
   endtask

   task automatic pulseFrame(input string name, input logic [NS-1:0] exp_mask);
      @(posedge vga_clk); #1;
      bus.frame_start = 1'b1;
      @(posedge vga_clk); #1;
      bus.frame_start = 1'b0;
      checkOutput({name, "_valid"}, 32'(collision_valid), 32'd1);
      checkOutput({name, "_mask"}, 32'(collision_mask), 32'(exp_mask));
   endtask

   task automatic writeAtFrame(input int idx, input int x, input int y);
      @(posedge vga_clk); #1;
      bus.pos_wr_en   = 1'b1;
      bus.pos_wr_idx  = 3'(idx);
      bus.pos_wr_x    = 10'(x);
      bus.pos_wr_y    = 9'(y);
      bus.frame_start = 1'b1;
      @(posedge vga_clk); #1;
      bus.pos_wr_en   = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   initial begin
      bus.col = '0; bus.row = '0; bus.disp_ena = 1'b0; bus.frame_start = 1'b0;
      bus.pos_wr_en = 1'b0; bus.pos_wr_idx = '0; bus.pos_wr_x = '0; bus.pos_wr_y = '0;
      rom_on     = 4'b1111;
      spr_enable = 4'b0001;
      spr_color  = {12'hFFF, 12'h00F, 12'h0F0, 12'h080};
      bg_color   = 12'h000;

      #50;
      checkOutput("rst_pix_rgb", 32'(pix_rgb), 32'd0);
      checkOutput("rst_pix_de", 32'(pix_de), 32'd0);
      checkOutput("rst_coll_mask", 32'(collision_mask), 32'd0);
      checkOutput("rst_coll_valid", 32'(collision_valid), 32'd0);
      checkOutput("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      @(negedge vga_clk);
      arst_n = 1'b1;

      $display("[TB] single sprite");
      writePos(0, 256, 176);
      pulseFrame("frame1", 4'b0000);
      @(posedge vga_clk); #1;
      checkOutput("frame1_valid_drop", 32'(collision_valid), 32'd0);
      applyStimulus(256, 176, 1'b1, 12'h080);
      applyStimulus(255, 176, 1'b1, 12'h000);
      applyStimulus(300, 200, 1'b1, 12'h080);
      idle(1);
      checkAddr("addr_300_200", 0, 14'd3116);
      checkAddr("addr_nohit_s1", 1, 14'd0);
      idle(4);

      $display("[TB] overlap priority");
      spr_color  = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
      spr_enable = 4'b0101;
      bg_color   = 12'h123;
      writePos(0, 100, 100);
      writePos(2, 150, 150);
      pulseFrame("frame2", 4'b0000);
      applyStimulus(160, 160, 1'b1, 12'hF00);
      applyStimulus(240, 240, 1'b1, 12'h00F);
      applyStimulus(50, 50, 1'b1, 12'h123);
      idle(4);
      pulseFrame("frame3", 4'b0101);
      pulseFrame("frame4", 4'b0000);

      $display("[TB] edge clipping");
      spr_enable = 4'b0010;
      writePos(1, 600, 400);
      pulseFrame("frame5", 4'b0000);
      applyStimulus(639, 479, 1'b1, 12'h0F0);
      idle(1);
      checkAddr("addr_edge", 1, 14'(79*128 + 39));
      applyStimulus(0, 0, 1'b1, 12'h123);
      idle(1);
      checkAddr("addr_nowrap", 1, 14'd0);
      idle(4);

      $display("[TB] double buffering");
      writePos(1, 10, 10);
      applyStimulus(20, 20, 1'b1, 12'h123);
      applyStimulus(639, 479, 1'b1, 12'h0F0);
      idle(4);
      pulseFrame("frame6", 4'b0000);
      applyStimulus(20, 20, 1'b1, 12'h0F0);
      applyStimulus(639, 479, 1'b1, 12'h123);
      idle(4);
      writeAtFrame(1, 300, 300);
      applyStimulus(301, 302, 1'b1, 12'h0F0);
      idle(1);
      checkAddr("addr_writethru", 1, 14'd257);
      applyStimulus(20, 20, 1'b1, 12'h123);
      idle(4);

      $display("[TB] transparency, enable, blanking");
      spr_enable = 4'b0101;
      rom_on     = 4'b0001;
      idle(2);
      applyStimulus(160, 160, 1'b1, 12'hF00);
      applyStimulus(240, 240, 1'b1, 12'h123);
      idle(4);
      rom_on     = 4'b1111;
      spr_enable = 4'b0001;
      idle(2);
      applyStimulus(160, 160, 1'b1, 12'hF00);
      applyStimulus(240, 240, 1'b1, 12'h123);
      idle(4);
      pulseFrame("frame7", 4'b0000);
      applyStimulus(160, 160, 1'b1, 12'hF00);
      applyStimulus(160, 160, 1'b0, 12'h000);
      applyStimulus(240, 240, 1'b1, 12'h123);
      idle(2);
      checkOutput("blank_pix_de", 32'(pix_de), 32'd0);
      checkOutput("blank_pix_rgb", 32'(pix_rgb), 32'd0);
      idle(4);

      $display("[TB] reset mid-frame");
      spr_enable = 4'b0101;
      idle(2);
      for (int k = 0; k < 4; k++) applyStimulus(160, 160, 1'b1, 12'hF00);
      @(posedge vga_clk); #1;
      arst_n       = 1'b0;
      bus.disp_ena = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("midrst_pix_rgb", 32'(pix_rgb), 32'd0);
      checkOutput("midrst_pix_de", 32'(pix_de), 32'd0);
      checkOutput("midrst_rom_addr", 32'(bus.rom_addr), 32'd0);
      checkOutput("midrst_coll_mask", 32'(collision_mask), 32'd0);
      spr_enable = 4'b0001;
      @(negedge vga_clk);
      arst_n = 1'b1;
      applyStimulus(5, 5, 1'b1, 12'hF00);
      applyStimulus(160, 160, 1'b1, 12'h123);
      idle(4);
      pulseFrame("frame8", 4'b0000);
      applyStimulus(5, 5, 1'b1, 12'hF00);
      idle(4);

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge vga_clk);
      checkOutput("drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
